// File: rtl/pulse_conditioner.sv
// pulse_conditioner
//   Per-channel front end for the correlator inputs. Each raw pulse line is
//   synchronised and optionally inverted. It is then level- or edge-detected
//   (global mode) and gated by a per-channel hold-off down-counter. Accepted
//   pulses drive out[]. Each accepted pulse is also counted in a saturating
//   hit counter with a sticky overflow flag.
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   pulse_in      raw asynchronous detector pulses
//   invert        per-channel polarity invert (1 = active low)
//   mode          00 level, 01 rising, 10 falling, 11 both edges
//   holdoff       dead-time in cycles loaded after an accepted edge
//   enable        1 = accept pulses
//   clear_counts  clear all hit counters and overflow flags
//   count_sel     channel index for counter readback
//   out           conditioned pulses, registered
//   overflow      sticky counter-saturation flags
//   count_data    hit count of channel count_sel, registered
module pulse_conditioner #(
  parameter int NUM_INPUTS   = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLDOFF_BITS = 4,
  parameter int COUNT_BITS   = 16,
  parameter int SEL_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_INPUTS-1:0]   pulse_in,
  input  logic [NUM_INPUTS-1:0]   invert,
  input  logic [1:0]              mode,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic                    enable,
  input  logic                    clear_counts,
  input  logic [SEL_BITS-1:0]     count_sel,
  output logic [NUM_INPUTS-1:0]   out,
  output logic [NUM_INPUTS-1:0]   overflow,
  output logic [COUNT_BITS-1:0]   count_data
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  logic [NUM_INPUTS-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_INPUTS-1:0]   prev_q;
  logic [ARM_W-1:0]        arm_q;
  logic [HOLDOFF_BITS-1:0] hc_q [NUM_INPUTS];
  logic [COUNT_BITS-1:0]   cnt_q [NUM_INPUTS];

  logic [NUM_INPUTS-1:0]   s;
  logic [NUM_INPUTS-1:0]   det;
  logic [NUM_INPUTS-1:0]   accept;
  logic                    armed;

  assign armed = (arm_q == '0);

  always_comb begin
    s   = sync_q[SYNC_STAGES-1] ^ invert;
    det = '0;
    case (mode)
      2'b00:   det = s;
      2'b01:   det = s & ~prev_q;
      2'b10:   det = ~s & prev_q;
      default: det = s ^ prev_q;
    endcase
    accept = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      // level mode ignores the hold-off counter
      accept[i] = det[i] & enable & armed & ((mode == 2'b00) || (hc_q[i] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q     <= '0;
      arm_q      <= ARM_LOAD;
      out        <= '0;
      overflow   <= '0;
      count_data <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        hc_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pulse_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s;
      out    <= accept;
      if (arm_q != '0) arm_q <= arm_q - ARM_W'(1);

      // read value is the counter before any same-cycle update
      if (int'(count_sel) < NUM_INPUTS) count_data <= cnt_q[count_sel];
      else                              count_data <= '0;

      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (accept[i] && (mode != 2'b00)) hc_q[i] <= holdoff;
        else if (hc_q[i] != '0)           hc_q[i] <= hc_q[i] - HOLDOFF_BITS'(1);

        // clear has priority over a same-cycle accept
        if (clear_counts) begin
          cnt_q[i]    <= '0;
          overflow[i] <= 1'b0;
        end else if (accept[i]) begin
          if (cnt_q[i] != CNT_MAX) cnt_q[i]    <= cnt_q[i] + COUNT_BITS'(1);
          else                     overflow[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
module tb_pulse_conditioner;
  localparam int N  = 12;
  localparam int SS = 2;
  localparam int HB = 4;
  localparam int CB = 4;
  localparam int SB = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  pulse_in = '0;
  logic [N-1:0]  invert = '0;
  logic [1:0]    mode = 2'b01;
  logic [HB-1:0] holdoff = '0;
  logic          enable = 1'b1;
  logic          clear_counts = 1'b0;
  logic [SB-1:0] count_sel = '0;
  logic [N-1:0]  out;
  logic [N-1:0]  overflow;
  logic [CB-1:0] count_data;

  pulse_conditioner #(
    .NUM_INPUTS(N), .SYNC_STAGES(SS), .HOLDOFF_BITS(HB),
    .COUNT_BITS(CB), .SEL_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .invert(invert),
    .mode(mode), .holdoff(holdoff), .enable(enable),
    .clear_counts(clear_counts), .count_sel(count_sel),
    .out(out), .overflow(overflow), .count_data(count_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time-based view. The synchronised sample is pulse_in delayed
  // by SS captures; arming is "SS+1 cycles since reset"; hold-off is
  // "cycles since last edge accept > holdoff captured at that accept".
  logic [N-1:0] m_hist [SS];
  logic [N-1:0] m_prev;
  int           m_since;
  int           m_cyc;
  int           m_last [N];
  int           m_hold [N];
  int           m_cnt  [N];
  logic [N-1:0] m_ovf;
  logic [N-1:0] m_out;
  int           m_cd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [N-1:0] s, det, acc;
    int cd_next;
    s = m_hist[SS-1] ^ invert;
    case (mode)
      2'b00:   det = s;
      2'b01:   det = s & ~m_prev;
      2'b10:   det = ~s & m_prev;
      default: det = s ^ m_prev;
    endcase
    for (int i = 0; i < N; i++)
      acc[i] = det[i] && enable && (m_since >= SS + 1) &&
               ((mode == 2'b00) || ((m_cyc - m_last[i]) > m_hold[i]));
    cd_next = (int'(count_sel) < N) ? m_cnt[count_sel] : 0;
    if (reset) begin
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      m_prev = '0; m_since = 0; m_ovf = '0; m_out = '0; m_cd = 0;
      for (int i = 0; i < N; i++) begin
        m_last[i] = -1000; m_hold[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] && mode != 2'b00) begin
          m_last[i] = m_cyc; m_hold[i] = int'(holdoff);
        end
        if (clear_counts) begin
          m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end else if (acc[i]) begin
          if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
          else                  m_cnt[i]++;
        end
      end
      m_out = acc;
      m_cd  = cd_next;
      m_prev = s;
      for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pulse_in;
      if (m_since < 1000) m_since++;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("count_data", 32'(count_data), 32'(m_cd));
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  int n3;

  initial begin
    m_cyc = 0;
    // 1: single rising edge, latency SS+1 edges, one-cycle pulse
    reset = 1'b1; ticks(2);
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_count_data", 32'(count_data), 32'h0);
    reset = 1'b0; ticks(5);
    pulse_in[0] = 1'b1;
    tick(); tick();
    chk("t1_out0_early", 32'(out[0]), 32'h0);
    tick();
    chk("t1_out0_pulse", 32'(out[0]), 32'h1);
    tick();
    chk("t1_out0_single", 32'(out[0]), 32'h0);
    ticks(6);
    tick();
    chk("t1_cnt0", 32'(count_data), 32'h1);

    // 2: hold-off 5, edges at 0,2,7 on ch3
    holdoff = 4'd5; n3 = 0;
    for (int t = 0; t < 8; t++) begin
      pulse_in[3] = (t == 0 || t == 2 || t == 7);
      tick(); n3 += int'(out[3]);
    end
    pulse_in[3] = 1'b0;
    for (int t = 0; t < 6; t++) begin tick(); n3 += int'(out[3]); end
    count_sel = 4'd3; ticks(2);
    chk("t2_pulses3", 32'(n3), 32'd2);
    chk("t2_cnt3", 32'(count_data), 32'd2);

    // 3: inverted idle lines through reset do not glitch
    holdoff = '0; invert = '1; pulse_in = '0; reset = 1'b1; ticks(2);
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin tick(); chk("t3_no_glitch", 32'(out), 32'h0); end
    mode = 2'b00; ticks(2);
    chk("t3_level_ones", 32'(out), 32'hFFF);

    // 4: saturation and sticky overflow, then clear
    invert = '0; mode = 2'b01; reset = 1'b1; ticks(2); reset = 1'b0; ticks(5);
    count_sel = 4'd1;
    for (int e = 0; e < 17; e++) begin
      pulse_in[1] = 1'b1; tick(); pulse_in[1] = 1'b0; tick();
    end
    ticks(4);
    chk("t4_cnt1_sat", 32'(count_data), 32'd15);
    chk("t4_ovf1", 32'(overflow[1]), 32'h1);
    clear_counts = 1'b1; tick(); clear_counts = 1'b0;
    chk("t4_ovf1_cleared", 32'(overflow[1]), 32'h0);
    tick();
    chk("t4_cnt1_cleared", 32'(count_data), 32'd0);

    // 5: clear beats a same-cycle accept; out-of-range select reads 0
    pulse_in[2] = 1'b1; tick(); tick();
    clear_counts = 1'b1; tick(); clear_counts = 1'b0;
    chk("t5_out2", 32'(out[2]), 32'h1);
    pulse_in[2] = 1'b0; count_sel = 4'd2; ticks(2);
    chk("t5_cnt2", 32'(count_data), 32'd0);
    pulse_in[4] = 1'b1; ticks(4); pulse_in[4] = 1'b0;
    count_sel = 4'd13; ticks(2);
    chk("t5_sel13", 32'(count_data), 32'd0);

    // 6: disabled blocks everything; both-edge mode counts both edges
    enable = 1'b0;
    for (int t = 0; t < 6; t++) begin
      pulse_in = ~pulse_in; tick(); chk("t6_disabled", 32'(out), 32'h0); tick();
    end
    pulse_in = '0; ticks(4);
    enable = 1'b1; mode = 2'b11; clear_counts = 1'b1; tick(); clear_counts = 1'b0;
    count_sel = 4'd5;
    pulse_in[5] = 1'b1; ticks(3); pulse_in[5] = 1'b0; ticks(4);
    chk("t6_both_edges", 32'(count_data), 32'd2);

    // randomized traffic against the model
    for (int t = 0; t < 800; t++) begin
      pulse_in = N'($urandom);
      if ($urandom_range(0, 15) == 0) invert = N'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) holdoff = HB'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      clear_counts = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 150) == 0);
      count_sel = SB'($urandom);
      tick();
    end
    reset = 1'b0; clear_counts = 1'b0;
    ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
